writeback_stage: RTL and testbench

Final stage of the pipelined Y86-64 core. Holds the W pipeline register, drives the register-file write ports (dstE/valE/dstM/valM), and owns the processor status state machine (run / halted / fault). It also keeps the retired-instruction and cycle counters. It sits between the memory stage, which feeds the m_* signals, and the register file and forwarding logic, which consume the W_*/w_* outputs.

---
 rtl/writeback_stage_if.sv | 40 ++++
 rtl/writeback_stage.sv | 129 ++++++++++++
 tb/tb_writeback_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Bundle between the memory stage, the writeback stage and its consumers
// (register file, forwarding logic, status and counter observers).
interface writeback_stage_if #(
  parameter int CNT_WIDTH = 32
);
  logic [2:0]           m_stat;
  logic [3:0]           m_icode;
  logic [63:0]          m_valE;
  logic [63:0]          m_valM;
  logic [3:0]           m_dstE;
  logic [3:0]           m_dstM;
  logic                 W_stall;

  logic [2:0]           W_stat;
  logic [3:0]           W_icode;
  logic [63:0]          W_valE;
  logic [63:0]          W_valM;
  logic [3:0]           W_dstE;
  logic [3:0]           W_dstM;
  logic [3:0]           w_dstE;
  logic [3:0]           w_dstM;
  logic [63:0]          w_valE;
  logic [63:0]          w_valM;
  logic [2:0]           proc_stat;
  logic                 halted;
  logic [CNT_WIDTH-1:0] retired;
  logic [CNT_WIDTH-1:0] cycles;

  modport master (
    output m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, W_stall,
    input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
           w_dstE, w_dstM, w_valE, w_valM, proc_stat, halted, retired, cycles
  );

  modport slave (
    input  m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, W_stall,
    output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM,
           w_dstE, w_dstM, w_valE, w_valM, proc_stat, halted, retired, cycles
  );
endinterface

// File: rtl/writeback_stage.sv
// Y86-64 writeback stage: W pipeline register, gated register-file writes,
// run/halted/fault status machine, retired-instruction and cycle counters.
module writeback_stage #(
  parameter int CNT_WIDTH = 32
) (
  input logic               clock,
  input logic               reset,
  writeback_stage_if.slave  bus
);

  localparam logic [2:0] SBUB  = 3'd0;
  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [2:0] SHLT  = 3'd2;
  localparam logic [2:0] SADR  = 3'd3;
  localparam logic [2:0] SINS  = 3'd4;
  localparam logic [3:0] INOP  = 4'd1;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] HALTED = 2'd1;
  localparam logic [1:0] FAULT  = 2'd2;

  logic [1:0]           state_q,   state_d;
  logic [2:0]           wStat_q,   wStat_d;
  logic [3:0]           wIcode_q,  wIcode_d;
  logic [63:0]          wValE_q,   wValE_d;
  logic [63:0]          wValM_q,   wValM_d;
  logic [3:0]           wDstE_q,   wDstE_d;
  logic [3:0]           wDstM_q,   wDstM_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic [CNT_WIDTH-1:0] cycles_q,  cycles_d;

  logic running;
  logic stopHalt;
  logic stopFault;
  logic holdW;
  logic writeEn;

  // The stopping edge also holds W so the offending instruction stays visible.
  always_comb begin
    running   = (state_q == RUN);
    stopHalt  = running && (wStat_q == SHLT);
    stopFault = running && (wStat_q >= SADR);
    holdW     = bus.W_stall || !running || stopHalt || stopFault;
    writeEn   = running && (wStat_q == SAOK);

    wStat_d  = wStat_q;
    wIcode_d = wIcode_q;
    wValE_d  = wValE_q;
    wValM_d  = wValM_q;
    wDstE_d  = wDstE_q;
    wDstM_d  = wDstM_q;
    if (!holdW) begin
      wStat_d  = bus.m_stat;
      wIcode_d = bus.m_icode;
      wValE_d  = bus.m_valE;
      wValM_d  = bus.m_valM;
      wDstE_d  = bus.m_dstE;
      wDstM_d  = bus.m_dstM;
    end

    state_d = state_q;
    if (stopHalt) begin
      state_d = HALTED;
    end else if (stopFault) begin
      state_d = FAULT;
    end

    retired_d = retired_q;
    if (writeEn && !bus.W_stall) begin
      retired_d = retired_q + CNT_WIDTH'(1);
    end

    cycles_d = cycles_q;
    if (running) begin
      cycles_d = cycles_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wStat_q   <= SBUB;
      wIcode_q  <= INOP;
      wValE_q   <= '0;
      wValM_q   <= '0;
      wDstE_q   <= RNONE;
      wDstM_q   <= RNONE;
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      wStat_q   <= wStat_d;
      wIcode_q  <= wIcode_d;
      wValE_q   <= wValE_d;
      wValM_q   <= wValM_d;
      wDstE_q   <= wDstE_d;
      wDstM_q   <= wDstM_d;
      retired_q <= retired_d;
      cycles_q  <= cycles_d;
    end
  end

  assign bus.W_stat  = wStat_q;
  assign bus.W_icode = wIcode_q;
  assign bus.W_valE  = wValE_q;
  assign bus.W_valM  = wValM_q;
  assign bus.W_dstE  = wDstE_q;
  assign bus.W_dstM  = wDstM_q;

  assign bus.w_dstE  = writeEn ? wDstE_q : RNONE;
  assign bus.w_dstM  = writeEn ? wDstM_q : RNONE;
  assign bus.w_valE  = wValE_q;
  assign bus.w_valM  = wValM_q;

  // Status codes 5..7 are reported as an invalid instruction once faulted.
  always_comb begin
    case (state_q)
      RUN:     bus.proc_stat = SAOK;
      HALTED:  bus.proc_stat = SHLT;
      default: bus.proc_stat = (wStat_q >= SINS) ? SINS : wStat_q;
    endcase
  end

  assign bus.halted  = !running;
  assign bus.retired = retired_q;
  assign bus.cycles  = cycles_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage with 4-bit counters so the
// wrap-around case is reachable in a handful of cycles.
module tb_writeback_stage;

  localparam int CW = 4;
  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;
  localparam logic [3:0] RNONE = 4'hF;

  logic clock;
  logic reset;
  int   vectorCount = 0;
  int   missCount   = 0;
  int   expCycles   = 0;
  bit   expRunning  = 1'b1;

  writeback_stage_if #(.CNT_WIDTH(CW)) bus ();

  writeback_stage #(.CNT_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] stat, input logic [3:0] icode,
                               input logic [63:0] valE, input logic [63:0] valM,
                               input logic [3:0] dstE, input logic [3:0] dstM,
                               input logic stall);
    bus.m_stat  = stat;
    bus.m_icode = icode;
    bus.m_valE  = valE;
    bus.m_valM  = valM;
    bus.m_dstE  = dstE;
    bus.m_dstM  = dstM;
    bus.W_stall = stall;
  endtask

  task automatic applyBubble(input logic stall);
    applyStimulus(SBUB, 4'h1, 64'h0, 64'h0, RNONE, RNONE, stall);
  endtask

  // Cycle counter expectation advances on each edge taken while still running.
  task automatic stepClock();
    @(posedge clock);
    if (expRunning) expCycles++;
    #1;
  endtask

  task automatic doReset();
    applyBubble(1'b0);
    reset = 1'b1;
    #1;
    @(negedge clock);
    reset      = 1'b0;
    expCycles  = 0;
    expRunning = 1'b1;
  endtask

  task automatic checkCycles(input string tag);
    checkOutput(tag, 64'(bus.cycles), 64'(expCycles % 16));
  endtask

  initial begin
    reset = 1'b1;
    applyBubble(1'b0);
    #1;
    checkOutput("reset.W_dstE",    64'(bus.W_dstE),    64'hF);
    checkOutput("reset.W_dstM",    64'(bus.W_dstM),    64'hF);
    checkOutput("reset.w_dstE",    64'(bus.w_dstE),    64'hF);
    checkOutput("reset.w_dstM",    64'(bus.w_dstM),    64'hF);
    checkOutput("reset.W_stat",    64'(bus.W_stat),    64'(SBUB));
    checkOutput("reset.W_icode",   64'(bus.W_icode),   64'h1);
    checkOutput("reset.proc_stat", 64'(bus.proc_stat), 64'(SAOK));
    checkOutput("reset.halted",    64'(bus.halted),    64'h0);
    checkOutput("reset.retired",   64'(bus.retired),   64'h0);
    checkOutput("reset.cycles",    64'(bus.cycles),    64'h0);
    @(negedge clock);
    reset = 1'b0;

    // OPq: one write cycle, retirement counted when it leaves W
    applyStimulus(SAOK, 4'h6, 64'h1234, 64'h0, 4'h3, RNONE, 1'b0);
    stepClock();
    checkOutput("opq.w_dstE",    64'(bus.w_dstE),  64'h3);
    checkOutput("opq.w_valE",    bus.w_valE,       64'h1234);
    checkOutput("opq.w_dstM",    64'(bus.w_dstM),  64'hF);
    checkOutput("opq.retired0",  64'(bus.retired), 64'h0);
    applyBubble(1'b0);
    stepClock();
    checkOutput("opq.w_dstE_gone", 64'(bus.w_dstE),  64'hF);
    checkOutput("opq.retired1",    64'(bus.retired), 64'h1);
    checkCycles("opq.cycles");

    // mrmovq held by three stall cycles
    applyStimulus(SAOK, 4'h5, 64'h0, 64'hDEAD, RNONE, 4'h0, 1'b0);
    stepClock();
    checkOutput("mrm.w_dstM", 64'(bus.w_dstM), 64'h0);
    checkOutput("mrm.w_valM", bus.w_valM,      64'hDEAD);
    checkOutput("mrm.retired_load", 64'(bus.retired), 64'h1);
    applyBubble(1'b1);
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput($sformatf("mrm.stall%0d.w_dstM", i), 64'(bus.w_dstM), 64'h0);
      checkOutput($sformatf("mrm.stall%0d.retired", i), 64'(bus.retired), 64'h1);
    end
    applyBubble(1'b0);
    stepClock();
    checkOutput("mrm.release.w_dstM",  64'(bus.w_dstM),  64'hF);
    checkOutput("mrm.release.retired", 64'(bus.retired), 64'h2);
    checkCycles("mrm.cycles");

    // Five SAOK instructions then a halt
    doReset();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(SAOK, 4'h6, 64'(i * 16), 64'h0, 4'(i), RNONE, 1'b0);
      stepClock();
      checkOutput($sformatf("halt.i%0d.w_dstE", i), 64'(bus.w_dstE), 64'(i));
    end
    applyStimulus(SHLT, 4'h0, 64'h77, 64'h0, RNONE, RNONE, 1'b0);
    stepClock();
    checkOutput("halt.inW.halted",    64'(bus.halted),    64'h0);
    checkOutput("halt.inW.proc_stat", 64'(bus.proc_stat), 64'(SAOK));
    checkOutput("halt.inW.retired",   64'(bus.retired),   64'h5);
    applyStimulus(SAOK, 4'h6, 64'h99, 64'h0, 4'h6, RNONE, 1'b0);
    stepClock();
    expRunning = 1'b0;
    checkOutput("halt.halted",    64'(bus.halted),    64'h1);
    checkOutput("halt.proc_stat", 64'(bus.proc_stat), 64'(SHLT));
    checkOutput("halt.W_stat",    64'(bus.W_stat),    64'(SHLT));
    checkOutput("halt.retired",   64'(bus.retired),   64'h5);
    checkCycles("halt.cycles");
    stepClock();
    stepClock();
    checkOutput("halt.frozen.w_dstE", 64'(bus.w_dstE), 64'hF);
    checkOutput("halt.frozen.W_valE", bus.W_valE,      64'h77);
    checkCycles("halt.frozen.cycles");

    // Stall and stop on the same edge: stop wins, halt stays in W
    doReset();
    applyStimulus(SHLT, 4'h0, 64'h0, 64'h0, RNONE, RNONE, 1'b0);
    stepClock();
    applyStimulus(SAOK, 4'h6, 64'h55, 64'h0, 4'h1, RNONE, 1'b1);
    stepClock();
    expRunning = 1'b0;
    checkOutput("stallstop.W_stat", 64'(bus.W_stat), 64'(SHLT));
    checkOutput("stallstop.halted", 64'(bus.halted), 64'h1);
    checkCycles("stallstop.cycles");

    // Address fault, sticky until reset
    doReset();
    applyStimulus(SADR, 4'h5, 64'h0, 64'h0, 4'h2, RNONE, 1'b0);
    stepClock();
    checkOutput("adr.inW.w_dstE",    64'(bus.w_dstE),    64'hF);
    checkOutput("adr.inW.proc_stat", 64'(bus.proc_stat), 64'(SAOK));
    applyStimulus(SAOK, 4'h6, 64'h1, 64'h0, 4'h4, RNONE, 1'b0);
    stepClock();
    expRunning = 1'b0;
    checkOutput("adr.proc_stat", 64'(bus.proc_stat), 64'(SADR));
    checkOutput("adr.halted",    64'(bus.halted),    64'h1);
    checkOutput("adr.W_dstE",    64'(bus.W_dstE),    64'h2);
    stepClock();
    stepClock();
    checkOutput("adr.sticky.halted",    64'(bus.halted),    64'h1);
    checkOutput("adr.sticky.proc_stat", 64'(bus.proc_stat), 64'(SADR));
    checkOutput("adr.sticky.w_dstE",    64'(bus.w_dstE),    64'hF);
    checkOutput("adr.sticky.retired",   64'(bus.retired),   64'h0);
    doReset();
    checkOutput("adr.reset.halted",    64'(bus.halted),    64'h0);
    checkOutput("adr.reset.proc_stat", 64'(bus.proc_stat), 64'(SAOK));

    // Status code 6 faults and reports as SINS
    applyStimulus(3'd6, 4'hC, 64'h0, 64'h0, 4'h1, RNONE, 1'b0);
    stepClock();
    checkOutput("ins.inW.w_dstE", 64'(bus.w_dstE), 64'hF);
    applyBubble(1'b0);
    stepClock();
    expRunning = 1'b0;
    checkOutput("ins.proc_stat", 64'(bus.proc_stat), 64'(SINS));
    checkOutput("ins.halted",    64'(bus.halted),    64'h1);

    // 17 retirements wrap the 4-bit counter to 1, then async reset mid-cycle
    doReset();
    for (int i = 1; i <= 18; i++) begin
      applyStimulus(SAOK, 4'h6, 64'(i), 64'h0, 4'(i % 15), RNONE, 1'b0);
      stepClock();
    end
    checkOutput("wrap.retired", 64'(bus.retired), 64'h1);
    checkOutput("wrap.W_dstE",  64'(bus.W_dstE),  64'h3);
    checkCycles("wrap.cycles");
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async.W_dstE",  64'(bus.W_dstE),  64'hF);
    checkOutput("async.w_dstE",  64'(bus.w_dstE),  64'hF);
    checkOutput("async.W_stat",  64'(bus.W_stat),  64'(SBUB));
    checkOutput("async.W_icode", 64'(bus.W_icode), 64'h1);
    checkOutput("async.W_valE",  bus.W_valE,       64'h0);
    checkOutput("async.retired", 64'(bus.retired), 64'h0);
    checkOutput("async.cycles",  64'(bus.cycles),  64'h0);
    @(negedge clock);
    reset      = 1'b0;
    expCycles  = 0;
    expRunning = 1'b1;
    applyStimulus(SAOK, 4'h6, 64'h42, 64'h0, 4'h7, RNONE, 1'b0);
    stepClock();
    checkOutput("async.firstload.w_dstE", 64'(bus.w_dstE), 64'h7);
    checkCycles("async.firstload.cycles");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
